usb1bd_rx_pkt_fifo: RTL and testbench

USB1BD_RX_PKT_FIFO -- requirements
Module: usb1bd_rx_pkt_fifo

---
 rtl/usb1bd_pkg.sv | 24 ++
 rtl/usb1bd_sync_ram.sv | 40 ++++
 rtl/usb1bd_rx_pkt_fifo.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usb1bd_rx_pkt_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb1bd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb1bd_pkg
// Purpose : Shared definitions for the USB1 receive packet FIFO.
//           - drop_cause encodings reported on a discarded packet
//           - receive state machine encoding
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package usb1bd_pkg;

  localparam logic [1:0] DROP_NONE  = 2'b00;
  localparam logic [1:0] DROP_CRC   = 2'b01;
  localparam logic [1:0] DROP_OVF   = 2'b10;
  localparam logic [1:0] DROP_SHORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

endpackage : usb1bd_pkg
`default_nettype wire

// File: rtl/usb1bd_sync_ram.sv
`default_nettype none
// ============================================================================
// Module  : usb1bd_sync_ram
// Purpose : DEPTH x 8 storage, one write port, one registered read port.
//           Contents are not reset.
// Ports   : clk            - clock
//           we/waddr/wdata - write port
//           re/raddr       - read request; rdata updates on the next edge
//           rdata          - registered read data, holds when re=0
// Revision: 1.0 - initial release
// ============================================================================
module usb1bd_sync_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : usb1bd_sync_ram
`default_nettype wire

// File: rtl/usb1bd_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : usb1bd_rx_pkt_fifo
// Purpose : Receive packet FIFO. Bytes of the open packet are stored
//           speculatively; the packet becomes readable only once it ends
//           with a good CRC, otherwise the write pointer rolls back. The two
//           trailing CRC16 bytes are held back by a 2-byte pipeline and never
//           stored.
// Ports   : clk, rst (async, active-low)
//           rx_fifo_data/dvalid/ddone, crc16_err, rx_abort - protocol side
//           flush                     - synchronous clear of everything
//           rd_en, rd_data            - read side (rd_data registered)
//           empty, avail_cnt          - committed, unread byte status
//           pkt_ok, pkt_len           - commit pulse / last committed length
//           pkt_drop, drop_cause      - drop pulse / last drop reason
// Revision: 1.0 - initial release
// ============================================================================
module usb1bd_rx_pkt_fifo
  import usb1bd_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_fifo_data,
  input  logic        rx_fifo_dvalid,
  input  logic        rx_fifo_ddone,
  input  logic        crc16_err,
  input  logic        rx_abort,
  input  logic        flush,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic [AW:0] avail_cnt,
  output logic        pkt_ok,
  output logic [AW:0] pkt_len,
  output logic        pkt_drop,
  output logic [1:0]  drop_cause
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ONE   = (AW+1)'(1);

  // state and pointers
  rx_state_e   r_state;
  rx_state_e   w_state_next;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_cm_ptr;
  logic        r_ovf;

  // hold pipeline: r_h0 is the oldest byte, r_hcnt how many are held
  logic [7:0]  r_h0;
  logic [7:0]  r_h1;
  logic [1:0]  r_hcnt;

  // status registers
  logic        r_pkt_ok;
  logic        r_pkt_drop;
  logic [AW:0] r_pkt_len;
  logic [1:0]  r_drop_cause;
  logic        r_rd_seen;

  // combinational
  logic        w_empty;
  logic        w_rd_fire;
  logic [AW:0] w_used;
  logic        w_shift;
  logic        w_store;
  logic        w_ovf_eff;
  logic [AW:0] w_wr_adv;
  logic [1:0]  w_hcnt_adv;
  logic        w_in_recv;
  logic        w_eop;
  logic        w_commit;
  logic        w_drop;
  logic [1:0]  w_drop_code;
  logic        w_end_pkt;
  logic [7:0]  w_ram_q;

  assign w_empty    = (r_cm_ptr == r_rd_ptr);
  assign w_rd_fire  = rd_en & ~w_empty & ~flush;
  // Occupancy includes the speculative bytes of the open packet; it is
  // measured against rd_ptr as it stands, so a read this cycle frees no
  // space until the next one.
  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_shift    = rx_fifo_dvalid & (r_hcnt == 2'd2);
  assign w_store    = w_shift & ~r_ovf & (w_used != c_DEPTH);
  assign w_ovf_eff  = r_ovf | (w_shift & (w_used == c_DEPTH));
  // Pointer / byte count including this cycle's byte, so a ddone arriving
  // with the last byte evaluates the packet with that byte taken.
  assign w_wr_adv   = w_store ? (r_wr_ptr + c_ONE) : r_wr_ptr;
  assign w_hcnt_adv = (rx_fifo_dvalid && (r_hcnt != 2'd2)) ? (r_hcnt + 2'd1) : r_hcnt;
  assign w_in_recv  = (r_state == ST_RECV);
  // A ddone only means something inside a packet (or with its first byte).
  assign w_eop      = rx_fifo_ddone & (w_in_recv | rx_fifo_dvalid);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and end-of-packet decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    w_drop_code  = DROP_NONE;
    w_end_pkt    = 1'b0;

    if (flush) begin
      w_state_next = ST_IDLE;
      w_end_pkt    = 1'b1;
    end else if (rx_abort) begin
      w_state_next = ST_IDLE;
      w_end_pkt    = 1'b1;
      if (w_in_recv) begin
        w_drop      = 1'b1;
        w_drop_code = DROP_SHORT;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A byte right after DONE starts the next packet immediately.
          if (rx_fifo_dvalid) begin
            w_state_next = rx_fifo_ddone ? ST_DONE : ST_RECV;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_RECV: begin
          if (rx_fifo_ddone) begin
            w_state_next = ST_DONE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase

      if (w_eop) begin
        w_end_pkt = 1'b1;
        if (crc16_err) begin
          w_drop      = 1'b1;
          w_drop_code = DROP_CRC;
        end else if (w_ovf_eff) begin
          w_drop      = 1'b1;
          w_drop_code = DROP_OVF;
        end else if (w_hcnt_adv != 2'd2) begin
          w_drop      = 1'b1;
          w_drop_code = DROP_SHORT;
        end else begin
          w_commit    = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, hold pipeline and overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cm_ptr <= '0;
      r_ovf    <= 1'b0;
      r_h0     <= 8'h00;
      r_h1     <= 8'h00;
      r_hcnt   <= 2'd0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_cm_ptr <= '0;
      end else if (w_commit) begin
        r_wr_ptr <= w_wr_adv;
        r_cm_ptr <= w_wr_adv;
      end else if (w_end_pkt) begin
        r_wr_ptr <= r_cm_ptr;
      end else begin
        r_wr_ptr <= w_wr_adv;
      end

      if (flush) begin
        r_rd_ptr <= '0;
      end else if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + c_ONE;
      end

      if (w_end_pkt) begin
        r_hcnt <= 2'd0;
        r_ovf  <= 1'b0;
      end else if (rx_fifo_dvalid) begin
        r_hcnt <= w_hcnt_adv;
        r_ovf  <= w_ovf_eff;
        case (r_hcnt)
          2'd0:    r_h0 <= rx_fifo_data;
          2'd1:    r_h1 <= rx_fifo_data;
          default: begin
            r_h0 <= r_h1;
            r_h1 <= rx_fifo_data;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_ok     <= 1'b0;
      r_pkt_drop   <= 1'b0;
      r_pkt_len    <= '0;
      r_drop_cause <= DROP_NONE;
      r_rd_seen    <= 1'b0;
    end else begin
      r_pkt_ok   <= w_commit;
      r_pkt_drop <= w_drop;
      if (w_commit) begin
        r_pkt_len <= w_wr_adv - r_cm_ptr;
      end
      if (w_drop) begin
        r_drop_cause <= w_drop_code;
      end
      if (w_rd_fire) begin
        r_rd_seen <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage. Write and read addresses never collide: the write side is
  // blocked once it is DEPTH ahead of the read pointer.
  // --------------------------------------------------------------------------
  usb1bd_sync_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_store & ~flush),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (r_h0),
    .re    (w_rd_fire),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_ram_q)
  );

  // The RAM output register has no reset; present 0 until the first read.
  assign rd_data    = r_rd_seen ? w_ram_q : 8'h00;
  assign empty      = w_empty;
  assign avail_cnt  = r_cm_ptr - r_rd_ptr;
  assign pkt_ok     = r_pkt_ok;
  assign pkt_len    = r_pkt_len;
  assign pkt_drop   = r_pkt_drop;
  assign drop_cause = r_drop_cause;

endmodule : usb1bd_rx_pkt_fifo
`default_nettype wire

// File: tb/tb_usb1bd_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb1bd_rx_pkt_fifo
// Purpose : Self-checking bench for usb1bd_rx_pkt_fifo (DEPTH=64). Packet
//           outcomes come from a vector table; payload bytes of expected
//           commits go to a scoreboard queue that every read is checked
//           against.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb1bd_rx_pkt_fifo;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_fifo_data;
  logic        rx_fifo_dvalid;
  logic        rx_fifo_ddone;
  logic        crc16_err;
  logic        rx_abort;
  logic        flush;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic [AW:0] avail_cnt;
  logic        pkt_ok;
  logic [AW:0] pkt_len;
  logic        pkt_drop;
  logic [1:0]  drop_cause;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  usb1bd_rx_pkt_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_dvalid(rx_fifo_dvalid),
    .rx_fifo_ddone(rx_fifo_ddone), .crc16_err(crc16_err),
    .rx_abort(rx_abort), .flush(flush), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .avail_cnt(avail_cnt),
    .pkt_ok(pkt_ok), .pkt_len(pkt_len), .pkt_drop(pkt_drop),
    .drop_cause(drop_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         nbytes;
    bit         crc;
    bit         merge;     // ddone together with the last byte
    bit         exp_ok;
    int         exp_len;
    logic [1:0] exp_cause;
    int         exp_avail;
    bit         drain;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock. A read that fires on this edge is checked against the
  // scoreboard right after it.
  task automatic cycle();
    bit pre;
    pre = rd_en && !empty;
    @(posedge clk);
    #1;
    if (pre) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      end
    end
  endtask

  task automatic send_pkt(input int n, input bit crc, input bit merge, input bit exp_ok,
                          input int exp_len, input logic [1:0] exp_cause);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) begin
      rx_fifo_data   = 8'($urandom_range(0, 255));
      b.push_back(rx_fifo_data);
      rx_fifo_dvalid = 1'b1;
      if (merge && i == n - 1) begin
        rx_fifo_ddone = 1'b1;
        crc16_err     = crc;
      end
      cycle();
    end
    rx_fifo_dvalid = 1'b0;
    if (!merge) begin
      rx_fifo_ddone = 1'b1;
      crc16_err     = crc;
      cycle();
    end
    rx_fifo_ddone = 1'b0;
    crc16_err     = 1'b0;
    chk("pkt_ok", {31'd0, pkt_ok}, {31'd0, exp_ok});
    chk("pkt_drop", {31'd0, pkt_drop}, {31'd0, !exp_ok});
    if (exp_ok) begin
      chk("pkt_len", {25'd0, pkt_len}, exp_len);
      for (int i = 0; i < n - 2; i++) sb.push_back(b[i]);
    end else begin
      chk("drop_cause", {30'd0, drop_cause}, {30'd0, exp_cause});
    end
    cycle();
    chk("pulse_end", {30'd0, pkt_ok, pkt_drop}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rd_en = 1'b0;
    chk("drain_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    logic [7:0] held;
    int budget;

    rst = 1'b0;
    rx_fifo_data = 8'h00; rx_fifo_dvalid = 1'b0; rx_fifo_ddone = 1'b0;
    crc16_err = 1'b0; rx_abort = 1'b0; flush = 1'b0; rd_en = 1'b0;
    #12 rst = 1'b1;
    cycle();

    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_avail", {25'd0, avail_cnt}, 32'd0);
    chk("rst_pkt_ok", {31'd0, pkt_ok}, 32'd0);
    chk("rst_pkt_drop", {31'd0, pkt_drop}, 32'd0);
    chk("rst_pkt_len", {25'd0, pkt_len}, 32'd0);
    chk("rst_drop_cause", {30'd0, drop_cause}, 32'd0);

    //            n   crc merge ok len cause  avail drain
    vecs.push_back('{5,  0, 0, 1, 3,  2'b00, 3,  1});
    vecs.push_back('{2,  0, 0, 1, 0,  2'b00, 0,  0});
    vecs.push_back('{1,  0, 0, 0, 0,  2'b11, 0,  0});
    vecs.push_back('{6,  0, 0, 1, 4,  2'b00, 4,  0});
    vecs.push_back('{8,  1, 0, 0, 0,  2'b01, 4,  1});
    vecs.push_back('{70, 0, 0, 0, 0,  2'b10, 0,  0});
    vecs.push_back('{10, 0, 0, 1, 8,  2'b00, 8,  1});
    vecs.push_back('{66, 0, 0, 1, 64, 2'b00, 64, 1});
    vecs.push_back('{67, 0, 0, 0, 0,  2'b10, 0,  0});
    vecs.push_back('{4,  0, 1, 1, 2,  2'b00, 2,  1});
    vecs.push_back('{1,  0, 1, 0, 0,  2'b11, 0,  0});

    foreach (vecs[k]) begin
      send_pkt(vecs[k].nbytes, vecs[k].crc, vecs[k].merge, vecs[k].exp_ok,
               vecs[k].exp_len, vecs[k].exp_cause);
      chk("avail_cnt", {25'd0, avail_cnt}, vecs[k].exp_avail);
      chk("empty", {31'd0, empty}, {31'd0, vecs[k].exp_avail == 0});
      if (vecs[k].drain) drain();
    end

    // Abort after 10 bytes, then flush with 5 committed bytes.
    for (int i = 0; i < 10; i++) begin
      rx_fifo_data = 8'($urandom_range(0, 255));
      rx_fifo_dvalid = 1'b1;
      cycle();
    end
    rx_fifo_dvalid = 1'b0;
    rx_abort = 1'b1;
    cycle();
    rx_abort = 1'b0;
    chk("abort_drop", {31'd0, pkt_drop}, 32'd1);
    chk("abort_cause", {30'd0, drop_cause}, 32'd3);
    chk("abort_avail", {25'd0, avail_cnt}, 32'd0);
    send_pkt(7, 0, 0, 1, 5, 2'b00);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    held = rd_data;
    chk("pre_flush_avail", {25'd0, avail_cnt}, 32'd4);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    sb.delete();
    chk("flush_avail", {25'd0, avail_cnt}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_pulses", {30'd0, pkt_ok, pkt_drop}, 32'd0);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_rd_held", {24'd0, rd_data}, {24'd0, held});
    end
    rd_en = 1'b0;

    // Continuous reading while four 40-byte packets commit (pointer wrap).
    rd_en = 1'b1;
    for (int p = 0; p < 4; p++) send_pkt(40, 0, 0, 1, 38, 2'b00);
    budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    rd_en = 1'b0;
    chk("wrap_sb_drained", sb.size(), 32'd0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Reset in the middle of a packet: no drop pulse, everything cleared.
    for (int i = 0; i < 5; i++) begin
      rx_fifo_data = 8'($urandom_range(0, 255));
      rx_fifo_dvalid = 1'b1;
      cycle();
    end
    #3 rst = 1'b0;
    #1;
    rx_fifo_dvalid = 1'b0;
    chk("mid_rst_drop", {31'd0, pkt_drop}, 32'd0);
    chk("mid_rst_avail", {25'd0, avail_cnt}, 32'd0);
    chk("mid_rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("mid_rst_pkt_len", {25'd0, pkt_len}, 32'd0);
    #3 rst = 1'b1;
    sb.delete();
    cycle();
    send_pkt(5, 0, 0, 1, 3, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_usb1bd_rx_pkt_fifo
`default_nettype wire
